framed_deserializer: RTL and testbench
======================================

# framed_deserializer

Serial-to-parallel front end of the FIR filter chain. It hunts the 1-bit input stream for a fixed sync pattern, then captures the next DATA_WIDTH bits MSB-first. Each completed word is presented as a one-cycle valid pulse for the FIR filter's sample input. It adds frame alignment that a free-running bit counter lacks, so the filter never consumes a word shifted by a slipped bit.

## Interface
- DATA_WIDTH, 24, payload bits per frame; must match the FIR filter's DATA_WIDTH.
- SYNC_WIDTH, 8, length of the sync pattern in bits (>= 2).
- SYNC_WORD, 8'hA5, sync pattern, MSB received first.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  block enable; when low, no bit is accepted and all state holds.
- i_din  in  1  serial data bit.
- i_din_valid  in  1  i_din carries a bit this cycle.
- ov_dout  out  DATA_WIDTH  last good payload word.
- o_dout_valid  out  1  one-cycle pulse: ov_dout updated.
- o_locked  out  1  high while a frame is being captured (not in HUNT).
- o_parity_err  out  1  one-cycle pulse on a parity failure; constant 0 when parity is compiled out.

## Operation
- A bit is accepted when i_en && i_din_valid. Nothing else advances state.
- The state machine has three states: HUNT, DATA and PARITY. PARITY exists only with the macro.
- HUNT:
  - Each accepted bit shifts into a SYNC_WIDTH-bit sync register.
  - When {sync_reg[SYNC_WIDTH-2:0], i_din} == SYNC_WORD, go to DATA with the bit counter at 0.
- DATA:
  - Each accepted bit shifts into the data register, MSB first, and the counter increments.
  - On the DATA_WIDTH-th bit:
    - Without parity: load ov_dout with {data_reg[DATA_WIDTH-2:0], i_din}, pulse o_dout_valid and return to HUNT.
    - With parity: go to PARITY.
- PARITY:
  - The next accepted bit is the even-parity bit.
  - If XOR of the payload and the parity bit is 0: load ov_dout, pulse o_dout_valid.
  - Otherwise: pulse o_parity_err and leave ov_dout unchanged.
  - Either way, return to HUNT.
- On every return to HUNT, the sync register clears to 0. A new frame needs all SYNC_WIDTH sync bits, and payload bits never form part of a sync match.
- Sync matching applies only in HUNT. A SYNC_WORD pattern inside the payload has no effect.
- ov_dout holds its value between frames; only a good frame changes it.

## Timing
- Reset values: ov_dout = 0, o_dout_valid = 0, o_locked = 0, o_parity_err = 0. State is HUNT, and the counter and shift registers are 0.
- Reset asserted mid-frame aborts the frame immediately. No valid or error pulse is produced for it.
- Output latency: o_dout_valid and o_parity_err are registered. They are high exactly one cycle, in the cycle after the final frame bit is accepted.
- o_locked is registered. It rises the cycle after the last sync bit is accepted and falls in the same cycle o_dout_valid or o_parity_err pulses.
- Back-to-back frames: the first sync bit of the next frame may be accepted in the cycle the valid pulse is high, and it is not lost.
- Gaps in i_din_valid, and cycles with i_en low, may occur anywhere in a frame. The frame continues when acceptance resumes.
- Minimum frame length is SYNC_WIDTH + DATA_WIDTH accepted bits, plus 1 with parity.
- The downstream FIR takes o_dout_valid as its enable. There is no back-pressure: a word not consumed before the next valid pulse is overwritten.

## Configuration
- FRAMED_DESERIALIZER_PARITY_EN:
  - Defined: the PARITY state exists, each frame carries one trailing even-parity bit, and o_parity_err is driven.
  - Undefined: frames end after the payload, the PARITY state and its logic are absent, and o_parity_err is tied to 0.

## Test plan
- Clean frame, parity off:
  - Stimulus: bits 0xA5 then 0x123456, one per cycle.
  - Response: o_locked high for 24 cycles; o_dout_valid pulses once, the cycle after the 32nd bit; ov_dout = 0x123456.
- Noise before sync:
  - Stimulus: 0xA4, 0x4A, then 0xA5 and 0xABCDEF.
  - Response: no lock during the noise; ov_dout = 0xABCDEF after the frame.
- Payload containing the sync pattern, and gaps:
  - Stimulus: 0xA5 then 0xA5A5A5, with i_din_valid low every other cycle.
  - Response: exactly one o_dout_valid pulse; ov_dout = 0xA5A5A5.
- Reset mid-frame:
  - Stimulus: pull i_rst_n low after sync plus 10 payload bits, then send a full frame with payload 0x000001.
  - Response: all outputs 0 during reset; no pulse for the aborted frame; ov_dout = 0x000001 afterwards.
- Parity enabled:
  - Stimulus: 0xA5, 0x000003, parity bit 0; then 0xA5, 0x000007, parity bit 0.
  - Response: the first frame pulses o_dout_valid with ov_dout = 0x000003. The second frame pulses o_parity_err and ov_dout stays 0x000003.
- i_en low for 5 cycles mid-payload, with i_din_valid high:
  - Response: the bits offered during those cycles are ignored and the frame completes with the bits accepted after i_en returns high.

Source files
------------

// File: rtl/framed_deserializer_if.sv
// Bit-stream input and framed-word output bundle of framed_deserializer.
// master drives the serial side and slave is the deserializer.
interface framed_deserializer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  i_en;
    logic                  i_din;
    logic                  i_din_valid;
    logic [DATA_WIDTH-1:0] ov_dout;
    logic                  o_dout_valid;
    logic                  o_locked;
    logic                  o_parity_err;

    modport master (
        output i_en, i_din, i_din_valid,
        input  ov_dout, o_dout_valid, o_locked, o_parity_err
    );

    modport slave (
        input  i_en, i_din, i_din_valid,
        output ov_dout, o_dout_valid, o_locked, o_parity_err
    );
endinterface

// File: rtl/framed_deserializer.sv
// Sync-hunting serial-to-parallel front end: find SYNC_WORD, then capture DATA_WIDTH bits MSB-first.
// Optional trailing even-parity bit is enabled with `define FRAMED_DESERIALIZER_PARITY_EN.
module framed_deserializer #(
    parameter int                    DATA_WIDTH = 24,
    parameter int                    SYNC_WIDTH = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    framed_deserializer_if.slave  bus,
    output logic [1:0]            o_dbg_state
);
    // Handshake: a bit is taken only when i_en && i_din_valid; there is no ready.
    // o_dout_valid is a single-cycle pulse with no back-pressure, so the consumer takes it as it comes.

    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int LAST   = DATA_WIDTH - 1;
    localparam int SREG_W = SYNC_WIDTH - 1;
`ifdef FRAMED_DESERIALIZER_PARITY_EN
    localparam int DREG_W = DATA_WIDTH;
`else
    localparam int DREG_W = DATA_WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1
`ifdef FRAMED_DESERIALIZER_PARITY_EN
        ,PARITY = 2'd2
`endif
    } state_t;

    state_t                state_q, state_d;
    // Only the older SYNC_WIDTH-1 bits are stored; the incoming bit completes the window.
    logic [SREG_W-1:0]     sync_q, sync_d;
    logic [DREG_W-1:0]     data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
`ifdef FRAMED_DESERIALIZER_PARITY_EN
    logic                  err_q, err_d;
`endif
    logic                  accept;

    assign accept = bus.i_en && bus.i_din_valid;

    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
`ifdef FRAMED_DESERIALIZER_PARITY_EN
        err_d   = 1'b0;
`endif
        if (accept) begin
            case (state_q)
                HUNT: begin
                    sync_d = SREG_W'({sync_q, bus.i_din});
                    if ({sync_q, bus.i_din} == SYNC_WORD) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    data_d = DREG_W'({data_q, bus.i_din});
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LAST)) begin
                        cnt_d = '0;
`ifdef FRAMED_DESERIALIZER_PARITY_EN
                        state_d = PARITY;
`else
                        dout_d  = {data_q, bus.i_din};
                        valid_d = 1'b1;
                        state_d = HUNT;
                        sync_d  = '0;
`endif
                    end
                end
`ifdef FRAMED_DESERIALIZER_PARITY_EN
                PARITY: begin
                    if ((^{data_q, bus.i_din}) == 1'b0) begin
                        dout_d  = data_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = HUNT;
                    sync_d  = '0;
                end
`endif
                default: begin
                    state_d = HUNT;
                    sync_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= HUNT;
            sync_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
`ifdef FRAMED_DESERIALIZER_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
`ifdef FRAMED_DESERIALIZER_PARITY_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.ov_dout      = dout_q;
    assign bus.o_dout_valid = valid_q;
    assign bus.o_locked     = (state_q != HUNT);
`ifdef FRAMED_DESERIALIZER_PARITY_EN
    assign bus.o_parity_err = err_q;
`else
    assign bus.o_parity_err = 1'b0;
`endif
    assign o_dbg_state      = state_q;
endmodule

// File: tb/tb_framed_deserializer.sv
// Self-checking bench for framed_deserializer: directed vector table, corner-case sequences,
// and a randomized bit stream checked against a window-scanning frame parser.
module tb_framed_deserializer;
    localparam int         DW   = 24;
    localparam int         W    = DW + 1;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef FRAMED_DESERIALIZER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // ---------------- clock / reset ----------------
    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [1:0] dbg_state;

    always #5 i_clk = ~i_clk;

    framed_deserializer_if #(.DATA_WIDTH(DW)) bus ();

    framed_deserializer #(
        .DATA_WIDTH(DW),
        .SYNC_WIDTH(8),
        .SYNC_WORD (SYNC)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            n_tests  = 0;
    int            n_fail   = 0;
    int            n_pulses = 0;
    int            lock_cnt = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mon_e;
    logic [DW-1:0] model_dout = '0;

    typedef struct {
        logic [15:0] noise;
        int          noise_len;
        logic [23:0] payload;
        bit          gap;
        logic [23:0] exp_dout;
        int          exp_lock;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every output pulse is matched against the next queued expectation {is_err, word}.
    always @(negedge i_clk) begin
        if (bus.o_dout_valid === 1'b1 || bus.o_parity_err === 1'b1) begin
            n_pulses++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b dout=0x%0h, no frame expected",
                         bus.o_dout_valid, bus.o_parity_err, bus.ov_dout);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.o_parity_err, bus.o_dout_valid, bus.ov_dout} !== {mon_e[DW], ~mon_e[DW], mon_e[DW-1:0]}) begin
                    n_fail++;
                    $display("FAIL frame_result: got err=%0b valid=%0b dout=0x%0h, expected err=%0b valid=%0b dout=0x%0h",
                             bus.o_parity_err, bus.o_dout_valid, bus.ov_dout, mon_e[DW], ~mon_e[DW], mon_e[DW-1:0]);
                end
            end
        end
    end

    function automatic void exp_good(input logic [DW-1:0] word);
        exp_q.push_back({1'b0, word});
        model_dout = word;
    endfunction

    function automatic void exp_bad();
        exp_q.push_back({1'b1, model_dout});
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic b, input logic v, input logic e);
        bus.i_din       = b;
        bus.i_din_valid = v;
        bus.i_en        = e;
        @(posedge i_clk);
        #1;
        if (bus.o_locked === 1'b1) lock_cnt++;
    endtask

    // One cycle in which no bit is accepted: either valid low or enable low.
    task automatic idle();
        if ($urandom_range(0, 1) == 0) drive(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        else                           drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    endtask

    task automatic put_bit(input logic b, input bit gap);
        drive(b, 1'b1, 1'b1);
        if (gap) idle();
    endtask

    task automatic send_raw(input logic [31:0] v, input int n, input bit gap);
        for (int j = n - 1; j >= 0; j--) put_bit(v[j], gap);
    endtask

    task automatic send_frame(input logic [DW-1:0] p);
        send_raw(32'(SYNC), 8, 1'b0);
        send_raw(32'(p), DW, 1'b0);
`ifdef FRAMED_DESERIALIZER_PARITY_EN
        send_raw(32'(^p), 1, 1'b0);
`endif
    endtask

    // ---------------- stimulus ----------------
    logic [32:0]   fb;
    int            nb;
    int            p0;
    bit            acc[$];
    int            nl, i, start;
    logic [7:0]    w;
    logic [DW-1:0] pay;
`ifdef FRAMED_DESERIALIZER_PARITY_EN
    logic          par;
`endif

    initial begin
        bus.i_en = 1'b0;
        bus.i_din = 1'b0;
        bus.i_din_valid = 1'b0;
        i_rst_n = 1'b0;

        vecs[0] = '{16'h0000, 0,  24'h123456, 1'b0, 24'h123456, 24};
        vecs[1] = '{16'hA44A, 16, 24'hABCDEF, 1'b0, 24'hABCDEF, 24};
        vecs[2] = '{16'h0000, 0,  24'hA5A5A5, 1'b1, 24'hA5A5A5, 48};
        vecs[3] = '{16'h00FF, 8,  24'h000000, 1'b0, 24'h000000, 24};
        vecs[4] = '{16'h000F, 4,  24'hFFFFFF, 1'b0, 24'hFFFFFF, 24};

        repeat (3) @(posedge i_clk);
        #1;
        check("reset_dout",   64'(bus.ov_dout), 0);
        check("reset_valid",  64'(bus.o_dout_valid), 0);
        check("reset_locked", 64'(bus.o_locked), 0);
        check("reset_err",    64'(bus.o_parity_err), 0);
        check("reset_state",  64'(dbg_state), 0);
        i_rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // ---- table-driven frames ----
        for (int r = 0; r < 5; r++) begin
            lock_cnt = 0;
            for (int j = vecs[r].noise_len - 1; j >= 0; j--) put_bit(vecs[r].noise[j], vecs[r].gap);
            check("noise_lock", 64'(lock_cnt), 0);
            fb = {1'b0, SYNC, vecs[r].payload};
            nb = 32;
`ifdef FRAMED_DESERIALIZER_PARITY_EN
            fb = {SYNC, vecs[r].payload, ^vecs[r].payload};
            nb = 33;
`endif
            exp_good(vecs[r].exp_dout);
            lock_cnt = 0;
            p0 = n_pulses;
            for (int j = nb - 1; j > 0; j--) put_bit(fb[j], vecs[r].gap);
            drive(fb[0], 1'b1, 1'b1);
            check("last_bit_valid",    64'(bus.o_dout_valid), 1);
            check("last_bit_unlocked", 64'(bus.o_locked), 0);
            drive(1'b0, 1'b0, 1'b1);
            check("valid_one_cycle", 64'(bus.o_dout_valid), 0);
            check("table_dout",      64'(bus.ov_dout), 64'(vecs[r].exp_dout));
            check("lock_cycles",     64'(lock_cnt), 64'(vecs[r].exp_lock + PAR_BITS * (vecs[r].gap ? 2 : 1)));
            check("pulse_count",     64'(n_pulses - p0), 1);
        end

        // ---- reset mid-frame aborts without a pulse ----
        send_raw(32'(SYNC), 8, 1'b0);
        send_raw(32'h0000_02C3, 10, 1'b0);
        check("pre_reset_locked", 64'(bus.o_locked), 1);
        i_rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 64'({bus.o_dout_valid, bus.o_locked, bus.o_parity_err, bus.ov_dout}), 0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        check("rst_hold_outputs", 64'({bus.o_dout_valid, bus.o_locked, bus.o_parity_err, bus.ov_dout}), 0);
        i_rst_n = 1'b1;
        model_dout = '0;
        exp_good(24'h000001);
        send_frame(24'h000001);
        drive(1'b0, 1'b0, 1'b1);
        check("after_reset_dout", 64'(bus.ov_dout), 24'h000001);

        // ---- enable low for 5 cycles mid-payload, offered bits must be ignored ----
        exp_good(24'h0F0F0F);
        p0 = n_pulses;
        send_raw(32'(SYNC), 8, 1'b0);
        send_raw(32'h0000_00F0, 12, 1'b0);
        repeat (5) drive(1'b0, 1'b1, 1'b0);
        check("en_low_locked", 64'(bus.o_locked), 1);
        send_raw(32'h0000_0F0F, 12, 1'b0);
`ifdef FRAMED_DESERIALIZER_PARITY_EN
        send_raw(32'(^24'h0F0F0F), 1, 1'b0);
`endif
        drive(1'b0, 1'b0, 1'b1);
        check("en_low_dout",  64'(bus.ov_dout), 24'h0F0F0F);
        check("en_low_pulse", 64'(n_pulses - p0), 1);

        // ---- back-to-back frames: next sync starts in the pulse cycle ----
        exp_good(24'hC3A55A);
        exp_good(24'h5A5A5A);
        p0 = n_pulses;
        send_frame(24'hC3A55A);
        send_frame(24'h5A5A5A);
        drive(1'b0, 1'b0, 1'b1);
        check("b2b_pulses", 64'(n_pulses - p0), 2);
        check("b2b_dout",   64'(bus.ov_dout), 24'h5A5A5A);

        // ---- payload tail plus one bit would spell the sync word ----
        exp_good(24'h000052);
        send_frame(24'h000052);
        put_bit(1'b1, 1'b0);
        check("no_payload_sync", 64'(bus.o_locked), 0);
        drive(1'b0, 1'b0, 1'b0);

`ifdef FRAMED_DESERIALIZER_PARITY_EN
        // ---- parity: good frame, then bad frame leaves ov_dout unchanged ----
        exp_good(24'h000003);
        send_raw(32'(SYNC), 8, 1'b0);
        send_raw(32'h3, DW, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        check("par_good_valid", 64'(bus.o_dout_valid), 1);
        drive(1'b0, 1'b0, 1'b1);
        check("par_good_dout", 64'(bus.ov_dout), 24'h000003);
        exp_bad();
        send_raw(32'(SYNC), 8, 1'b0);
        send_raw(32'h7, DW, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        check("par_bad_err",   64'(bus.o_parity_err), 1);
        check("par_bad_valid", 64'(bus.o_dout_valid), 0);
        drive(1'b0, 1'b0, 1'b1);
        check("par_bad_err_gone", 64'(bus.o_parity_err), 0);
        check("par_bad_dout",     64'(bus.ov_dout), 24'h000003);
`endif

        // ---- randomized stream: noise + frames, with idle cycles sprinkled in ----
        acc.delete();
        for (int s = 0; s < 40; s++) begin
            nl = $urandom_range(0, 12);
            for (int k = 0; k < nl; k++) acc.push_back(1'($urandom_range(0, 1)));
            pay = DW'($urandom);
            for (int k = 7; k >= 0; k--) acc.push_back(SYNC[k]);
            for (int k = DW - 1; k >= 0; k--) acc.push_back(pay[k]);
`ifdef FRAMED_DESERIALIZER_PARITY_EN
            acc.push_back((^pay) ^ ($urandom_range(0, 3) == 0));
`endif
        end

        // Reference parse: a frame starts where the last 8 bits since the previous frame end equal SYNC.
        i = 0;
        start = 0;
        while (i < acc.size()) begin
            w = '0;
            if (i - start >= 7)
                for (int k = 7; k >= 0; k--) w = {w[6:0], 1'(acc[i - k])};
            if (i - start >= 7 && w == SYNC) begin
                if (i + DW + PAR_BITS < acc.size()) begin
                    pay = '0;
                    for (int k = 1; k <= DW; k++) pay = {pay[DW-2:0], 1'(acc[i + k])};
`ifdef FRAMED_DESERIALIZER_PARITY_EN
                    par = acc[i + DW + 1];
                    if (((^pay) ^ par) == 1'b0) exp_good(pay);
                    else                        exp_bad();
`else
                    exp_good(pay);
`endif
                    start = i + DW + PAR_BITS + 1;
                    i = start;
                end else begin
                    i = acc.size();
                end
            end else begin
                i++;
            end
        end

        foreach (acc[k]) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) idle();
            drive(acc[k], 1'b1, 1'b1);
        end
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        check("random_all_frames_seen", 64'(exp_q.size()), 0);
        check("random_final_dout",      64'(bus.ov_dout), 64'(model_dout));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
